// File: rtl/soc_event_pkg.sv
// Shared types and constants for the SoC event scheduler and its integrators.
package soc_event_pkg;

  localparam int NB_SRC_DEF       = 32;
  localparam int EVT_ID_WIDTH_DEF = 8;

  typedef logic [EVT_ID_WIDTH_DEF-1:0] evt_id_t;

  // Interrupt line that integrators conventionally attach the event FIFO to.
  localparam evt_id_t FIFO_EVT_IRQ_ID = evt_id_t'(26);

endpackage

// File: rtl/event_rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping. Combinational, zero latency.
// No handshake; the caller decides whether to consume the winner.
module event_rr_picker #(
  parameter int NB_SRC = 32,
  parameter int IDX_W  = $clog2(NB_SRC)
) (
  input  logic [NB_SRC-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              any_vld,
  output logic [IDX_W-1:0]  winner
);

  logic [NB_SRC-1:0] rot;
  logic [IDX_W-1:0]  off;
  logic [IDX_W:0]    sum;

  always_comb begin
    // Rotating the doubled vector puts req[ptr] at bit 0, so the lowest set bit is the winner.
    rot = NB_SRC'({req, req} >> ptr);
    off = '0;
    for (int k = NB_SRC - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NB_SRC)) sum = sum - (IDX_W+1)'(NB_SRC);
    winner = sum[IDX_W-1:0];
  end

  assign any_vld = |req;

endmodule

// File: rtl/soc_event_scheduler.sv
// Latches source pulses as pending and serialises them round-robin as event IDs; pulse to valid is 2 cycles.
// Single-entry output register holds ID/valid stable under backpressure; 1 event/cycle while ready is high.
module soc_event_scheduler
  import soc_event_pkg::*;
#(
  parameter int NB_SRC       = NB_SRC_DEF,
  parameter int EVT_ID_WIDTH = EVT_ID_WIDTH_DEF,
  parameter int ID_BASE      = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NB_SRC-1:0]       src_evt_i,
  input  logic [NB_SRC-1:0]       src_en_i,
  output logic                    evt_valid_o,
  output logic [EVT_ID_WIDTH-1:0] evt_data_o,
  input  logic                    evt_ready_i,
  output logic [NB_SRC-1:0]       pending_o,
  output logic [NB_SRC-1:0]       err_ovf_o,
  input  logic [NB_SRC-1:0]       err_clr_i
);

  localparam int IDX_W = $clog2(NB_SRC);

  if (NB_SRC < 2 || NB_SRC > 256) begin : g_nb_src_chk
    $error("soc_event_scheduler: NB_SRC must be in 2..256");
  end
  if (ID_BASE + NB_SRC > 2**EVT_ID_WIDTH) begin : g_id_range_chk
    $error("soc_event_scheduler: ID_BASE+NB_SRC exceeds the event ID space");
  end

  logic [NB_SRC-1:0]       pending_q, ovf_q;
  logic [NB_SRC-1:0]       elig, set_vec, load_vec, ovf_set;
  logic [IDX_W-1:0]        rr_ptr_q, winner;
  logic                    any_elig, load;
  logic                    evt_valid_q;
  logic [EVT_ID_WIDTH-1:0] evt_data_q;

  // Disabled sources keep their pending bit but sit out arbitration.
  assign elig = pending_q & src_en_i;

  event_rr_picker #(
    .NB_SRC (NB_SRC),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req     (elig),
    .ptr     (rr_ptr_q),
    .any_vld (any_elig),
    .winner  (winner)
  );

  assign load     = (!evt_valid_q || evt_ready_i) && any_elig;
  assign load_vec = load ? (NB_SRC'(1) << winner) : '0;
  assign set_vec  = src_evt_i & src_en_i;
  assign ovf_set  = set_vec & pending_q & ~load_vec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      // A pulse landing on the cycle its source is granted re-arms pending.
      pending_q <= (pending_q & ~load_vec) | set_vec;
      ovf_q     <= (ovf_q & ~err_clr_i) | ovf_set;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else if (load) begin
      evt_valid_q <= 1'b1;
      evt_data_q  <= EVT_ID_WIDTH'(ID_BASE + 32'(winner));
      rr_ptr_q    <= (winner == IDX_W'(NB_SRC - 1)) ? '0 : winner + IDX_W'(1);
    end else if (evt_ready_i) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_data_o  = evt_data_q;
  assign pending_o   = pending_q;
  assign err_ovf_o   = ovf_q;

endmodule

// File: tb/tb_soc_event_scheduler.sv
// Self-checking bench: table of round-robin vectors plus hand sequences, IDs checked through a scoreboard queue.
// A second instance with ID_BASE=64 runs in lockstep to check ID offsetting.
module tb_soc_event_scheduler;

  localparam int NB = 32;

  typedef struct {
    logic [NB-1:0]  pulse;
    int             n;
    logic [2:0][7:0] ids;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] src_evt, src_en, err_clr;
  logic          ready;
  logic          valid, valid1;
  logic [7:0]    data, data1;
  logic [NB-1:0] pending, pending1, ovf, ovf1;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  soc_event_scheduler #(.NB_SRC(NB), .EVT_ID_WIDTH(8), .ID_BASE(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_evt_i(src_evt), .src_en_i(src_en),
    .evt_valid_o(valid), .evt_data_o(data), .evt_ready_i(ready),
    .pending_o(pending), .err_ovf_o(ovf), .err_clr_i(err_clr)
  );

  soc_event_scheduler #(.NB_SRC(NB), .EVT_ID_WIDTH(8), .ID_BASE(64)) dut_b64 (
    .clk_i(clk), .rst_ni(rst_n), .src_evt_i(src_evt), .src_en_i(src_en),
    .evt_valid_o(valid1), .evt_data_o(data1), .evt_ready_i(ready),
    .pending_o(pending1), .err_ovf_o(ovf1), .err_clr_i(err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [NB-1:0] p, input int n,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    vec_t v;
    v.pulse  = p;
    v.n      = n;
    v.ids[0] = a;
    v.ids[1] = b;
    v.ids[2] = c;
    return v;
  endfunction

  // Scoreboard: every accepted transfer must match the oldest expected ID.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_evt: got id %0d, expected no event", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("evt_id", {24'd0, data}, {24'd0, e});
        chk("evt_id_base64", {23'd0, valid1, data1}, {23'd0, 1'b1, 8'(e + 8'd64)});
      end
    end
  end

  vec_t tbl[5];

  initial begin
    tbl[0] = mk((NB'(1) << 3) | (NB'(1) << 7) | (NB'(1) << 30), 3, 8'd3, 8'd7, 8'd30);
    tbl[1] = mk((NB'(1) << 3) | (NB'(1) << 7), 2, 8'd3, 8'd7, 8'd0);
    tbl[2] = mk(NB'(1) << 5, 1, 8'd5, 8'd0, 8'd0);
    tbl[3] = mk((NB'(1) << 1) | (NB'(1) << 6), 2, 8'd6, 8'd1, 8'd0);
    tbl[4] = mk((NB'(1) << 0) | (NB'(1) << 31), 2, 8'd31, 8'd0, 8'd0);

    rst_n   = 1'b0;
    src_evt = '0;
    src_en  = '1;
    err_clr = '0;
    ready   = 1'b1;
    #3;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_ovf", ovf, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single event latency: pending at t+1, valid at t+2, idle at t+3.
    exp_q.push_back(8'd5);
    src_evt = NB'(1) << 5;
    tick();
    src_evt = '0;
    chk("lat_t1_valid", {31'd0, valid}, 32'd0);
    chk("lat_t1_pending", pending, 32'h20);
    tick();
    chk("lat_t2_valid", {31'd0, valid}, 32'd1);
    chk("lat_t2_data", {24'd0, data}, 32'd5);
    tick();
    chk("lat_t3_valid", {31'd0, valid}, 32'd0);
    chk("lat_t3_pending", pending, 32'd0);

    // Fresh reset so the table starts from pointer 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < tbl[v].n; k++) exp_q.push_back(tbl[v].ids[k]);
      src_evt = tbl[v].pulse;
      tick();
      src_evt = '0;
      repeat (tbl[v].n + 1) tick();
      chk("rr_back_to_back", exp_q.size(), 32'd0);
      chk("rr_idle_valid", {31'd0, valid}, 32'd0);
    end

    // Backpressure: head ID held stable, then both drain in order.
    ready = 1'b0;
    exp_q.push_back(8'd10);
    exp_q.push_back(8'd12);
    src_evt = (NB'(1) << 10) | (NB'(1) << 12);
    tick();
    src_evt = '0;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold_valid", {31'd0, valid}, 32'd1);
      chk("bp_hold_data", {24'd0, data}, 32'd10);
      tick();
    end
    chk("bp_pending", pending, 32'h1000);
    ready = 1'b1;
    repeat (3) tick();
    chk("bp_drained", exp_q.size(), 32'd0);
    chk("bp_no_ovf", ovf, 32'd0);
    chk("bp_idle_valid", {31'd0, valid}, 32'd0);

    // Overflow with the output register occupied by source 20.
    ready = 1'b0;
    exp_q.push_back(8'd20);
    exp_q.push_back(8'd2);
    src_evt = NB'(1) << 20;
    tick();
    src_evt = '0;
    tick();
    src_evt = NB'(1) << 2;
    tick();
    src_evt = '0;
    chk("ovf_first_pulse", ovf, 32'd0);
    chk("ovf_pending", pending, 32'h4);
    tick();
    src_evt = NB'(1) << 2;
    tick();
    chk("ovf_set", ovf, 32'h4);
    err_clr = NB'(1) << 2;
    tick();
    chk("ovf_set_wins", ovf, 32'h4);
    src_evt = '0;
    tick();
    err_clr = '0;
    chk("ovf_clear", ovf, 32'd0);
    chk("ovf_hold_data", {24'd0, data}, 32'd20);
    ready = 1'b1;
    repeat (3) tick();
    chk("ovf_single_emit", exp_q.size(), 32'd0);
    chk("ovf_pending_done", pending, 32'd0);

    // Enable gating.
    src_en  = ~(NB'(1) << 4);
    src_evt = NB'(1) << 4;
    tick();
    src_evt = '0;
    chk("en_drop_pending", pending, 32'd0);
    tick();
    chk("en_drop_valid", {31'd0, valid}, 32'd0);
    src_en  = '1;
    src_evt = NB'(1) << 9;
    tick();
    src_evt = '0;
    src_en  = ~(NB'(1) << 9);
    for (int c = 0; c < 5; c++) begin
      chk("en_held_valid", {31'd0, valid}, 32'd0);
      tick();
    end
    chk("en_held_pending", pending, 32'h200);
    exp_q.push_back(8'd9);
    src_en = '1;
    tick();
    tick();
    chk("en_reenable_emit", exp_q.size(), 32'd0);
    chk("en_reenable_pending", pending, 32'd0);

    // Reset mid-transfer with three events pending and an overflow flag set.
    ready   = 1'b0;
    src_evt = NB'(4'hF) << 1;
    tick();
    src_evt = '0;
    tick();
    chk("mid_valid", {31'd0, valid}, 32'd1);
    chk("mid_data", {24'd0, data}, 32'd1);
    chk("mid_pending", pending, 32'h1C);
    src_evt = NB'(1) << 2;
    tick();
    src_evt = '0;
    chk("mid_ovf", ovf, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_data", {24'd0, data}, 32'd0);
    chk("arst_pending", pending, 32'd0);
    chk("arst_ovf", ovf, 32'd0);
    chk("arst_valid_b64", {31'd0, valid1}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (10) tick();
    chk("post_rst_valid", {31'd0, valid}, 32'd0);
    chk("post_rst_pending", pending, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
